// File: rtl/mux_3_if.sv
// Data/select bundle for the registered 4:1 selector.
// The master drives the four data words, select and enable; the slave returns y.
interface mux_3_if #(
    parameter int WIDTH = 3
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] d;
    logic [1:0]       se;
    logic             en;
    logic [WIDTH-1:0] y;

    modport master (
        output a, b, c, d, se, en,
        input  y
    );

    modport slave (
        input  a, b, c, d, se, en,
        output y
    );
endinterface

// File: rtl/mux_3.sv
// Registered 4:1 selector with enable: y takes the chosen word one clock after sampling,
// or DISABLE_VAL while disabled. Synchronous active-high reset clears y to zero.
module mux_3 #(
    parameter int               WIDTH       = 3,
    parameter logic [WIDTH-1:0] DISABLE_VAL = '0
) (
    input logic   clk,
    input logic   rst,
    mux_3_if.slave bus
);

    logic [WIDTH-1:0] y_q;
    logic [WIDTH-1:0] y_d;

    // An unknown select falls through to the default arm, so y never goes X.
    always_comb begin
        y_d = DISABLE_VAL;
        if (bus.en) begin
            case (bus.se)
                2'b00:   y_d = bus.a;
                2'b01:   y_d = bus.b;
                2'b10:   y_d = bus.c;
                2'b11:   y_d = bus.d;
                default: y_d = DISABLE_VAL;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q <= '0;
        end else begin
            y_q <= y_d;
        end
    end

    assign bus.y = y_q;

endmodule

// File: tb/tb_mux_3.sv
// Directed check of mux_3: reset, select sweep, disable/re-enable, latency and unknown select.
module tb_mux_3;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    mux_3_if #(.WIDTH(3)) bus ();

    mux_3 #(.WIDTH(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;

        // reset holds y at zero even with a valid selection pending
        rst = 1'b1; bus.en = 1'b1; bus.se = 2'b11;
        bus.a = 3'd0; bus.b = 3'd1; bus.c = 3'd2; bus.d = 3'd3;
        tick(); chk("rst_edge1", bus.y, 3'b000);
        tick(); chk("rst_edge2", bus.y, 3'b000);
        rst = 1'b0;
        tick(); chk("rst_release", bus.y, 3'b011);

        // select sweep
        bus.se = 2'b00; tick(); chk("sel_a", bus.y, 3'b000);
        bus.se = 2'b01; tick(); chk("sel_b", bus.y, 3'b001);
        bus.se = 2'b10; tick(); chk("sel_c", bus.y, 3'b010);
        bus.se = 2'b11; tick(); chk("sel_d", bus.y, 3'b011);

        // disable forces zero regardless of se and data
        bus.en = 1'b0; tick(); chk("dis", bus.y, 3'b000);
        bus.se = 2'b01; tick(); chk("dis_se01", bus.y, 3'b000);
        bus.se = 2'b10; bus.c = 3'b110; tick(); chk("dis_se10", bus.y, 3'b000);
        bus.c = 3'b010;

        // re-enable picks up the new selection immediately
        bus.en = 1'b1; bus.se = 2'b00; tick(); chk("reen_a", bus.y, 3'b000);
        bus.se = 2'b01; tick(); chk("reen_b", bus.y, 3'b001);

        // simultaneous en and se change
        bus.en = 1'b0; bus.se = 2'b11; tick(); chk("simul_dis", bus.y, 3'b000);
        bus.en = 1'b1; bus.se = 2'b10; tick(); chk("simul_en", bus.y, 3'b010);

        // mid-cycle data change only appears after the next edge
        bus.c = 3'b111; #2;
        chk("mid_cycle_hold", bus.y, 3'b010);
        tick(); chk("track_c", bus.y, 3'b111);

        // full-width data through each port
        bus.a = 3'b101; bus.se = 2'b00; tick(); chk("wide_a", bus.y, 3'b101);
        bus.d = 3'b110; bus.se = 2'b11; tick(); chk("wide_d", bus.y, 3'b110);
        bus.d = 3'b011; tick(); chk("run_d", bus.y, 3'b011);

        // reset mid-operation clears y on that edge
        rst = 1'b1; tick(); chk("mid_rst", bus.y, 3'b000);
        rst = 1'b0;

        // unknown select: b and d zeroed so a two-state resolution of se also yields zero
        bus.b = 3'b000; bus.d = 3'b000; bus.en = 1'b1; bus.se = 2'bx1;
        tick(); chk("x_sel", bus.y, 3'b000);
        total++;
        assert ((^bus.y) !== 1'bx) else begin
            bad++;
            $error("FAIL x_sel_known observed=%b expected=known", bus.y);
        end

        // recovery after the unknown select
        bus.se = 2'b00; tick(); chk("post_x_a", bus.y, 3'b101);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux_3.md
Name: mux_3

Overview:
- Registered 4:1 multiplexer with enable for WIDTH-bit data words.
- Selects one of four inputs a/b/c/d using a 2-bit select (se).
- Drives the result on y one clock after sampling; y is zero while disabled.
- Used as a generic datapath selector wherever a clocked, reset-clean select stage is needed.

Parameters:
- WIDTH, 3, bit width of each data input and of output y (legal: 1..64).
- DISABLE_VAL, 0 (WIDTH bits), value loaded into y when en=0.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- a  input  WIDTH  data input, selected when se=2'b00.
- b  input  WIDTH  data input, selected when se=2'b01.
- c  input  WIDTH  data input, selected when se=2'b10.
- d  input  WIDTH  data input, selected when se=2'b11.
- se  input  2  select line.
- en  input  1  enable; 1 = pass the selected input, 0 = force DISABLE_VAL.
- y  output  WIDTH  registered output.

Behaviour:
- Clocking and reset:
  - Single clock domain; clk is the only clock.
  - rst is synchronous and active-high.
  - On a rising clk edge with rst=1, y <= 0 regardless of en, se or data.
  - Reset has priority over all other inputs.
  - Reset asserted mid-operation clears y on that same edge.
  - y stays 0 for every edge while rst=1.
- Normal operation (rising edge with rst=0):
  - en=1, se=00 -> y <= a
  - en=1, se=01 -> y <= b
  - en=1, se=10 -> y <= c
  - en=1, se=11 -> y <= d
  - en=0 -> y <= DISABLE_VAL (0 by default), independent of se and data.
  - se containing X/Z with en=1 -> y <= DISABLE_VAL (defined, non-X output).
- Latency and timing:
  - Latency is exactly 1 clock from sampled inputs to y.
  - No combinational path from any input to y.
  - Throughput: one new selection per clock.
  - Changes to inputs between clock edges have no effect on y.
- Other rules:
  - Width: pure bit copy, no arithmetic, no sign/zero extension; all data ports are exactly WIDTH bits.
  - Simultaneous se and en change: both are sampled on the same edge, and the result follows the rules above for the new values.
  - en toggling: re-enabling after a disable takes effect on the first edge where en=1 is sampled. No history is kept; the previous selection is not restored unless se selects it.
  - No internal state other than the y register.
  - Power-up value of y before the first reset is unspecified.

Test Plan:
- Reset: a=0,b=1,c=2,d=3, en=1, se=11, rst=1 for 2 edges -> y=3'b000. Release rst; next edge -> y=3'b011.
- Select sweep: a=000,b=001,c=010,d=011, en=1; se=00,01,10,11 on successive edges -> y=000,001,010,011, each one cycle after its se value.
- Disable: en=1, se=11 (y=011), then en=0 -> next edge y=000. se changes while en=0 -> y remains 000.
- Re-enable: from en=0, set en=1, se=00 -> y=000 (a). Then se=01 -> y=001 one edge later.
- Data tracking and latency: en=1, se=10, c changes 010->111 between edges -> y shows 111 only after the next rising edge, with no mid-cycle change.
- Mid-operation reset plus X select: running with y=011, assert rst for one edge -> y=000. Then en=1, se=2'bx1 -> y=000 (no X on output).
